// File: rtl/encode_out_pkg.sv
// encode_out_pkg: shared FSM encoding, LZS widths and halfword byte-swap helper.
package encode_out_pkg;
    typedef enum logic [2:0] {RUN, PADH, PADW, WAIT, DONE} state_t;
    localparam int CODE_MAX_W = 13;
    localparam int HALF_W = 16;
    localparam int WORD_W = 64;
    // decode_in uses the same swap, so a fetched word replays the bits in stream order
    function automatic logic [HALF_W-1:0] bswap16(input logic [HALF_W-1:0] h);
        return {h[7:0], h[15:8]};
    endfunction
endpackage

// File: rtl/encode_wordbuf.sv
// encode_wordbuf: assembles four halfwords into a 64-bit word and hands it to the FIFO.
module encode_wordbuf
    import encode_out_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              drain,
    input  logic              pad,
    input  logic [HALF_W-1:0] half,
    input  logic              dst_full,
    output logic [1:0]        hcnt,
    output logic              wvalid,
    output logic [WORD_W-1:0] fo,
    output logic              put,
    output logic              slot_free
);
    logic [WORD_W-1:0] wbuf, next_wbuf;
    assign put = ce & wvalid & ~dst_full;
    assign slot_free = ~wvalid | put;
    always_comb begin
        next_wbuf = wbuf;
        next_wbuf[{hcnt, 4'd0} +: HALF_W] = pad ? '0 : bswap16(half);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbuf <= '0;
            hcnt <= '0;
            wvalid <= 1'b0;
            fo <= '0;
        end else if (ce) begin
            if (drain) begin
                wbuf <= next_wbuf;
                hcnt <= hcnt + 2'd1;
                if (hcnt == 2'd3) fo <= next_wbuf;
            end
            wvalid <= (drain && hcnt == 2'd3) ? 1'b1 : put ? 1'b0 : wvalid;
        end
    end
endmodule

// File: rtl/encode_out.sv
// encode_out: packs 1-13 bit LZS code fields MSB-first into 64-bit FIFO words, with zero-pad flush.
module encode_out
    import encode_out_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [12:0]       stream_data,
    input  logic [3:0]        stream_width,
    input  logic              stream_valid,
    output logic              stream_ack,
    input  logic              stream_flush,
    output logic              flush_done,
    input  logic              dst_full,
    output logic [WORD_W-1:0] fo,
    output logic              m_dst_putn
);
    state_t      state;
    logic [31:0] acc, ins;
    logic [5:0]  fill;
    logic [3:0]  wc;
    logic [12:0] code;
    logic [1:0]  hcnt;
    logic        wvalid, put, slot_free, drain;
    assign wc = stream_width > 4'(CODE_MAX_W) ? 4'(CODE_MAX_W) : stream_width;
    assign code = stream_data & 13'((14'd1 << wc) - 14'd1);
    assign ins = {19'd0, code} << (6'd32 - fill - {2'b0, wc});
    assign stream_ack = ce & stream_valid & (state == RUN) & (fill < 6'(HALF_W));
    // a partial tail in PADH leaves as one halfword whose low bits are already zero
    assign drain = ce & slot_free & ((fill >= 6'(HALF_W)) | (state == PADH && fill != 6'd0)
                                     | (state == PADW && hcnt != 2'd0));
    assign m_dst_putn = ce ? ~put : 1'bz;
    encode_wordbuf u_wb (
        .clk(clk), .rst(rst), .ce(ce), .drain(drain), .pad(state == PADW),
        .half(acc[31:16]), .dst_full(dst_full), .hcnt(hcnt), .wvalid(wvalid),
        .fo(fo), .put(put), .slot_free(slot_free)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            fill <= '0;
            state <= RUN;
            flush_done <= 1'b0;
        end else if (ce) begin
            if (stream_ack) begin
                acc <= acc | ins;
                fill <= fill + {2'b0, wc};
            end else if (drain) begin
                acc <= acc << HALF_W;
                fill <= fill >= 6'(HALF_W) ? fill - 6'(HALF_W) : 6'd0;
            end
            flush_done <= 1'b0;
            case (state)
                RUN:  if (stream_flush) state <= PADH;
                PADH: if (fill == 6'd0) state <= hcnt != 2'd0 ? PADW : WAIT;
                PADW: if (hcnt == 2'd0) state <= WAIT;
                WAIT: if (!wvalid) begin
                    state <= DONE;
                    flush_done <= 1'b1;
                end
                DONE: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end
endmodule
